// File: rtl/uart_tx_if.sv
// uart_tx_if: byte valid/ready handshake between a byte source and the UART transmitter
interface uart_tx_if;
  logic [7:0] in_data;
  logic       in_flag;
  logic       in_ready;
  modport master (output in_data, output in_flag, input in_ready);
  modport slave  (input in_data, input in_flag, output in_ready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: LSB-first UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN is defined)
module uart_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 9600
) (
  input  logic      sys_clk,
  input  logic      sys_rst,
  uart_tx_if.slave  in_if,
  output logic      tx,
  output logic      tx_busy,
  output logic      tx_done
);
  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam logic [31:0] BPS_LAST = 32'(BPS_CNT - 1);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        wrap;
`ifdef UART_TX_PARITY_EN
  logic        par_q, par_d;
`endif
  assign wrap = cnt_q == BPS_LAST;
  assign tx = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;
  assign in_if.in_ready = ready_q;
  // next-state logic; outputs are derived from the next state so they register glitch-free
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    bit_cnt_d = bit_cnt_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    par_d = par_q;
`endif
    if (state_q == IDLE) begin
      if (in_if.in_flag && ready_q) begin
        state_d = START;
        shift_d = in_if.in_data;
        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
        par_d = ^in_if.in_data;
`endif
      end
    end else begin
      cnt_d = wrap ? '0 : cnt_q + 32'd1;
      if (wrap) begin
        case (state_q)
          START: state_d = DATA;
          DATA: begin
            shift_d = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef UART_TX_PARITY_EN
            if (bit_cnt_q == 3'd7) state_d = PARITY;
`else
            if (bit_cnt_q == 3'd7) state_d = STOP;
`endif
          end
`ifdef UART_TX_PARITY_EN
          PARITY: state_d = STOP;
`endif
          STOP: state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
    tx_d = state_d != START && (state_d != DATA || shift_d[0]);
`ifdef UART_TX_PARITY_EN
    if (state_d == PARITY) tx_d = par_d;
`endif
    ready_d = state_d == IDLE;
    busy_d = state_d != IDLE;
    done_d = state_d == STOP && cnt_d == BPS_LAST;
  end
  // state and registered outputs; reset drops the frame and idles the line at once
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
      ready_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
      done_q <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx with a bit-level line monitor
module tb_uart_tx;
  localparam int BPS = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk, rst, tx, tx_busy, tx_done;
  int cyc = 0, total = 0, bad = 0, frames = 0;
  logic [7:0] exp_q[$];
  int hs_q[$];
  uart_tx_if bus();
  uart_tx #(.CLK_FREQ(1000), .UART_BPS(100)) dut (
    .sys_clk(clk), .sys_rst(rst), .in_if(bus), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial forever @(posedge clk) cyc++;
  initial begin
    #1000000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at cyc %0d", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [10:0] mk_bits(input logic [7:0] b);
    logic [10:0] e;
    e = '1;
    e[0] = 1'b0;
    e[8:1] = b;
    if (NB == 11) e[9] = ^b;
    return e;
  endfunction
  // line monitor: decodes every frame and checks each cycle against the expected waveform
  initial begin
    int pos, gl;
    logic [10:0] eb, ob;
    pos = -1;
    gl = 0;
    eb = '1;
    ob = '1;
    forever begin
      @(negedge clk);
      if (rst) begin
        pos = -1;
        continue;
      end
      if (pos < 0 && tx_done) chk("stray_done", 32'(tx_done), 0);
      if (pos < 0 && !tx) begin
        pos = 0;
        ob = '1;
        gl = 0;
        if (exp_q.size() == 0) begin
          chk("unexp_frame", exp_q.size(), 1);
          eb = '1;
          eb[0] = 1'b0;
        end else begin
          eb = mk_bits(exp_q.pop_front());
          chk("start_lat", cyc, hs_q.pop_front() + 1);
        end
      end
      if (pos >= 0) begin
        if (tx !== eb[pos/BPS] || tx_busy !== 1'b1 || bus.in_ready !== 1'b0 || tx_done !== (pos == NB*BPS-1)) gl++;
        if (pos % BPS == BPS/2) ob[pos/BPS] = tx;
        pos++;
        if (pos == NB*BPS) begin
          chk("frame_bits", 32'(ob), 32'(eb));
          chk("frame_glitch", gl, 0);
          frames++;
          pos = -1;
        end
      end
    end
  end
  task automatic send(input logic [7:0] b, output int hs);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_data = b;
    bus.in_flag = 1'b1;
    while (!bus.in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("hs_timeout", 32'(n < 400), 1);
    hs = cyc;
    exp_q.push_back(b);
    hs_q.push_back(cyc);
    @(posedge clk);
    #1;
    bus.in_flag = 1'b0;
    bus.in_data = 8'($urandom);
  endtask
  task automatic wait_done(input int hs, input int lat);
    int n;
    n = 0;
    while (!tx_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("done_lat", cyc - hs, lat);
    @(negedge clk);
    chk("ready_after", 32'(bus.in_ready), 1);
  endtask
  initial begin
    int h, h1, h2;
    rst = 1'b1;
    bus.in_flag = 1'b0;
    bus.in_data = 8'h00;
    repeat (3) begin
      @(negedge clk);
      chk("reset_outs", {tx, bus.in_ready, tx_busy, tx_done}, 4'b1100);
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("idle_outs", {tx, bus.in_ready, tx_busy, tx_done}, 4'b1100);
    end
    send(8'hA5, h);
    wait_done(h, NB*BPS);
    send(8'h00, h1);
    send(8'hFF, h2);
    chk("b2b_gap", h2 - h1, NB*BPS + 1);
    wait_done(h2, NB*BPS);
    send(8'h55, h);
    repeat (40) @(negedge clk);
    bus.in_data = 8'h3C;
    bus.in_flag = 1'b1;
    @(negedge clk);
    bus.in_flag = 1'b0;
    wait_done(h, NB*BPS);
    repeat (30) @(negedge clk);
    chk("ignored_frames", frames, 4);
    send(8'h81, h);
    repeat (45) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async", {tx, bus.in_ready, tx_busy, tx_done}, 4'b1100);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst", {tx, bus.in_ready, tx_busy, tx_done}, 4'b1100);
    end
    send(8'h81, h);
    wait_done(h, NB*BPS);
    send(8'h07, h);
    wait_done(h, NB*BPS);
    repeat (30) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    chk("frames", frames, 6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, the sending counterpart of the team's 8N1 UART receiver. Accepts one byte per valid/ready handshake and serialises it LSB-first on a registered tx line. Format: one start bit (0), 8 data bits, optional even parity, one stop bit (1). Sits between the byte source (loopback/echo logic, command formatter) and the FPGA TX pin.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
UART_BPS, 9600, baud rate in bit/s
BPS_CNT (localparam), CLK_FREQ/UART_BPS (5208 at defaults), clock cycles per bit, integer division truncates

Ports:
sys_clk  input  1  system clock; one clock domain, all logic on its rising edge
sys_rst  input  1  reset; asynchronous and active-high
in_data  input  8  byte to transmit; sampled only on an accepted handshake
in_flag  input  1  byte valid; accepted when in_flag=1 and in_ready=1 in the same cycle
in_ready  output  1  block idle and able to accept a byte
tx  output  1  serial output, registered, idle high
tx_busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse at the end of the stop bit

Behaviour:
- Reset values: tx=1, in_ready=1, tx_busy=0, tx_done=0, state=IDLE, counters=0, shift register=0.
- Reset is asynchronous. Asserting it mid-frame forces tx=1 and IDLE immediately. The partial frame is abandoned and no tx_done is issued.
- States: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
- IDLE: in_ready=1, tx_busy=0, tx=1. On an accepted handshake in cycle N: latch in_data into the shift register, go to START. tx=0 from cycle N+1. in_ready=0 and tx_busy=1 from N+1.
- Baud counter: counts 0..BPS_CNT-1 in every non-IDLE state and wraps to 0 at BPS_CNT-1. Each wrap ends the current bit, so every bit lasts exactly BPS_CNT cycles. The counter is held at 0 in IDLE.
- START: tx=0 for one bit, then DATA.
- DATA: tx = shift register bit 0. At each bit end, shift right and increment bit_cnt (0..7). After the bit with bit_cnt=7 ends, go to PARITY (feature on) or STOP.
- STOP: tx=1 for one bit. In the last cycle of the stop bit, tx_done=1 for exactly one cycle, and the next state is IDLE.
- Frame length: 10*BPS_CNT cycles from the first tx=0 cycle to the first IDLE cycle (11*BPS_CNT with parity).
- Back-to-back: in_ready returns to 1 in the first IDLE cycle after tx_done. A handshake in that cycle starts the next frame with no idle gap beyond that one cycle.
- in_flag while in_ready=0 is ignored, neither queued nor flagged. in_data changes during a frame do not affect the frame in progress.
- tx is driven from a flop, never combinationally from state, so it is glitch-free.
- Counter widths: baud counter wide enough to hold BPS_CNT-1 (32 bits acceptable); bit_cnt 3 bits.

Optional Feature:
UART_TX_PARITY_EN
- Defined: a PARITY state is inserted after DATA. tx = XOR of the latched byte (even parity) for one bit. Frame is 11 bits.
- Undefined: no PARITY state and no parity logic. Frame is 10 bits (8N1), matching the existing receiver.

Test Plan:
Bench params: CLK_FREQ=1000, UART_BPS=100, so BPS_CNT=10.
1. Reset: sys_rst=1 for 3 cycles, then release. Required: tx=1, in_ready=1, tx_busy=0, tx_done=0 throughout.
2. Send 0xA5: handshake in cycle N. Required: tx=0 in cycles N+1..N+10. Data bits 1,0,1,0,0,1,0,1 at 10 cycles each. Stop bit 1 for 10 cycles. tx_done high in exactly one cycle, N+100. in_ready=1 at N+101.
3. Back-to-back 0x00 then 0xFF: second in_flag held high and accepted at the first in_ready cycle. Required: second start bit begins one cycle after the first frame's IDLE cycle. Both frames decode correctly through a bench UART model.
4. Ignored request: pulse in_flag with 0x3C midway through the 0x55 frame. Required: tx waveform identical to a lone 0x55 frame, only one tx_done, no 0x3C frame follows.
5. Reset mid-frame: assert sys_rst during data bit 3 of 0x81. Required: tx=1 in the same cycle, no tx_done, in_ready=1 after release. A following 0x81 frame is clean.
6. UART_TX_PARITY_EN defined, send 0x07. Required: parity bit=1, frame 110 cycles, tx_done at N+110. Macro undefined: same stimulus gives tx_done at N+100.
